project_ram_dp: RTL

Parametrised dual-port on-chip RAM. Two independent Avalon-MM slaves, s1 (port A) and s2 (port B), share one inferred memory array. Compared with the single-port RAM it adds configurable width and depth, a pipelined read path with 1 or 2 cycles of latency, readdatavalid and waitrequest handshakes, defined collision rules, and out-of-range handling. It replaces the single-port RAM wherever the CPU and a DMA or video master need concurrent access.

---
 rtl/project_ram_dp.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/project_ram_dp.sv
// rtl/project_ram_dp.sv - dual-port Avalon-MM RAM with 1/2-cycle pipelined reads
// Optional byte parity storage and read error flags: define PROJECT_RAM_DP_PARITY_EN.

module project_ram_dp #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 1536,
  parameter int ADDR_W       = 11,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "project_ram.hex"
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clken,
  input  logic              reset_req,
`ifdef PROJECT_RAM_DP_PARITY_EN
  input  logic              a_parity_inject,
  input  logic              b_parity_inject,
  output logic              a_readerr,
  output logic              b_readerr,
`endif
  input  logic              a_chipselect,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W/8-1:0] a_byteenable,
  input  logic [DATA_W-1:0] a_writedata,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  output logic              a_waitrequest,
  input  logic              b_chipselect,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W/8-1:0] b_byteenable,
  input  logic [DATA_W-1:0] b_writedata,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  output logic              b_waitrequest
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
`ifdef PROJECT_RAM_DP_PARITY_EN
  // Pipeline word carries the parity error flag above the data bits.
  localparam int PW = DATA_W + 1;
`else
  localparam int PW = DATA_W;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef PROJECT_RAM_DP_PARITY_EN
  logic [NB-1:0]     par [DEPTH];
  logic [1:0]        inj;
  assign inj = {b_parity_inject, a_parity_inject};
`endif

  logic              stall;
  logic [1:0]        cs, rd, wr, wr_acc, rd_acc, in_rng;
  logic [ADDR_W-1:0] addr  [2];
  logic [ADDR_W-1:0] idx   [2];
  logic [NB-1:0]     be    [2];
  logic [DATA_W-1:0] wdata [2];
  logic [PW-1:0]     rd_word [2];

  assign stall         = ~clken | reset_req;
  assign a_waitrequest = stall;
  assign b_waitrequest = stall;

  assign cs       = {b_chipselect, a_chipselect};
  assign rd       = {b_read, a_read};
  assign wr       = {b_write, a_write};
  assign addr[0]  = a_address;
  assign addr[1]  = b_address;
  assign be[0]    = a_byteenable;
  assign be[1]    = b_byteenable;
  assign wdata[0] = a_writedata;
  assign wdata[1] = b_writedata;

  always_comb begin
`ifdef PROJECT_RAM_DP_PARITY_EN
    logic err;
    err = 1'b0;
`endif
    in_rng = '0;
    wr_acc = '0;
    rd_acc = '0;
    for (int p = 0; p < 2; p++) begin
      in_rng[p]  = ({1'b0, addr[p]} < DEPTH_L);
      idx[p]     = in_rng[p] ? addr[p] : '0;
      wr_acc[p]  = ~stall & cs[p] & wr[p];
      rd_acc[p]  = ~stall & cs[p] & rd[p] & ~wr[p];
      rd_word[p] = '0;
`ifdef PROJECT_RAM_DP_PARITY_EN
      err = 1'b0;
      for (int i = 0; i < NB; i++)
        err = err | (^{mem[idx[p]][i*8 +: 8], par[idx[p]][i]});
      if (in_rng[p]) rd_word[p] = {err, mem[idx[p]]};
`else
      if (in_rng[p]) rd_word[p] = mem[idx[p]];
`endif
    end
  end

  // Port B is applied first so port A's lanes win on a same-word collision.
  always_ff @(posedge clk) begin
    for (int p = 1; p >= 0; p--) begin
      if (wr_acc[p] && in_rng[p]) begin
        for (int i = 0; i < NB; i++) begin
          if (be[p][i]) begin
            mem[idx[p]][i*8 +: 8] <= wdata[p][i*8 +: 8];
`ifdef PROJECT_RAM_DP_PARITY_EN
            par[idx[p]][i] <= (^wdata[p][i*8 +: 8]) ^ inj[p];
`endif
          end
        end
      end
    end
  end

  logic [1:0]    s1_vld;
  logic [PW-1:0] s1_data [2];
  logic [1:0]    out_vld;
  logic [PW-1:0] out_data [2];

  // Data registers only load on a real read so readdata holds between results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= '0;
      for (int p = 0; p < 2; p++) s1_data[p] <= '0;
    end else if (!stall) begin
      s1_vld <= rd_acc;
      for (int p = 0; p < 2; p++)
        if (rd_acc[p]) s1_data[p] <= rd_word[p];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [1:0]    s2_vld;
      logic [PW-1:0] s2_data [2];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s2_vld <= '0;
          for (int p = 0; p < 2; p++) s2_data[p] <= '0;
        end else if (!stall) begin
          s2_vld <= s1_vld;
          for (int p = 0; p < 2; p++)
            if (s1_vld[p]) s2_data[p] <= s1_data[p];
        end
      end
      assign out_vld     = s2_vld;
      assign out_data[0] = s2_data[0];
      assign out_data[1] = s2_data[1];
    end else begin : g_lat1
      assign out_vld     = s1_vld;
      assign out_data[0] = s1_data[0];
      assign out_data[1] = s1_data[1];
    end
  endgenerate

  assign a_readdatavalid = out_vld[0] & ~stall;
  assign b_readdatavalid = out_vld[1] & ~stall;
  assign a_readdata      = out_data[0][DATA_W-1:0];
  assign b_readdata      = out_data[1][DATA_W-1:0];
`ifdef PROJECT_RAM_DP_PARITY_EN
  assign a_readerr       = out_data[0][DATA_W] & a_readdatavalid;
  assign b_readerr       = out_data[1][DATA_W] & b_readdatavalid;
`endif

endmodule
